// File: rtl/icache_assoc_pkg.sv
// Shared types, derived-width helpers and address-field slices for the set-associative I-cache.
// Address layout: {tag, index, word offset, 2'b00}.
`ifndef ICACHE_ASSOC_PKG_SV
`define ICACHE_ASSOC_PKG_SV

`define ICACHE_ASSOC_OFF(a, off_w) a[(off_w)+1:2]
`define ICACHE_ASSOC_IDX(a, off_w, idx_w) a[(off_w)+(idx_w)+1:(off_w)+2]
`define ICACHE_ASSOC_TAG(a, off_w, idx_w, addr_w) a[(addr_w)-1:(off_w)+(idx_w)+2]

package icache_assoc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StMissReq,
        StRefill,
        StDrain
    } state_e;

    function automatic int unsigned calc_way_w(int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int unsigned calc_idx_w(int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned calc_off_w(int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned calc_tag_w(int unsigned addr_w, int unsigned sets,
                                               int unsigned line_words);
        return addr_w - calc_idx_w(sets) - calc_off_w(line_words) - 2;
    endfunction

endpackage

`endif

// File: rtl/icache_victim_sel.sv
// Victim way selection: lowest invalid way first, otherwise the set's round-robin pointer.
// Pointers advance only when a round-robin choice actually completes a refill.
module icache_victim_sel
    import icache_assoc_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned SETS = 64,
    localparam int unsigned WAY_W = calc_way_w(WAYS),
    localparam int unsigned IDX_W = calc_idx_w(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] index,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic             advance,
    input  logic             flush_clear,
    output logic [WAY_W-1:0] way,
    output logic             rr_used
);

    logic [WAY_W-1:0] rr_ptr_q [SETS];
    logic [WAY_W-1:0] inv_way;
    logic             any_invalid;
    logic [WAY_W-1:0] ptr_next;

    always_comb begin
        inv_way     = '0;
        any_invalid = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                inv_way     = WAY_W'(i);
                any_invalid = 1'b1;
            end
        end
    end

    assign rr_used = ~any_invalid;
    assign way     = any_invalid ? inv_way : rr_ptr_q[index];

    // Power-of-two WAYS makes the natural WAY_W wrap equal to mod WAYS.
    assign ptr_next = (WAYS > 1) ? rr_ptr_q[index] + WAY_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else if (flush_clear) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else if (advance) begin
            rr_ptr_q[index] <= ptr_next;
        end
    end

endmodule

// File: rtl/icache_ctrl_assoc.sv
// N-way set-associative I-cache controller with critical-word early restart and a
// flush-safe drain of in-flight refill bursts.
module icache_ctrl_assoc
    import icache_assoc_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned WAY_W = calc_way_w(WAYS),
    localparam int unsigned IDX_W = calc_idx_w(SETS),
    localparam int unsigned OFF_W = calc_off_w(LINE_WORDS),
    localparam int unsigned TAG_W = calc_tag_w(ADDR_W, SETS, LINE_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic                 cpu_req,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    input  logic                 flush,
    output logic [IDX_W-1:0]     tag_lookup_index,
    output logic [TAG_W-1:0]     tag_lookup_tag,
    input  logic [WAYS-1:0]      tag_hit_vec,
    input  logic [WAYS-1:0]      tag_valid_vec,
    output logic                 tag_update_valid,
    output logic [WAY_W-1:0]     tag_update_way,
    output logic [IDX_W-1:0]     tag_update_index,
    output logic [TAG_W-1:0]     tag_update_tag,
    output logic                 tag_flush_all,
    output logic [IDX_W-1:0]     data_read_index,
    output logic [OFF_W-1:0]     data_read_offset,
    input  logic [32*WAYS-1:0]   data_read_data,
    output logic                 data_write_enable,
    output logic [WAY_W-1:0]     data_write_way,
    output logic [IDX_W-1:0]     data_write_index,
    output logic [OFF_W-1:0]     data_write_offset,
    output logic [31:0]          data_write_data,
    output logic [ADDR_W-1:0]    refill_addr,
    output logic                 refill_start,
    input  logic                 refill_busy,
    input  logic                 refill_done,
    input  logic [31:0]          refill_data,
    input  logic [OFF_W-1:0]     refill_word,
    input  logic                 refill_data_valid,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
);

    state_e state_q, state_d;

    logic              cpu_ready_q, cpu_ready_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              refill_start_q, refill_start_d;
    logic              tag_update_q, tag_update_d;
    logic              flush_all_q, flush_all_d;
    logic              dwe_q, dwe_d;
    logic [OFF_W-1:0]  dw_off_q, dw_off_d;
    logic [31:0]       dw_data_q, dw_data_d;
    logic [ADDR_W-1:0] refill_addr_q, refill_addr_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [OFF_W-1:0]  miss_off_q, miss_off_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              rr_used_q, rr_used_d;
    logic [31:0]       crit_q, crit_d;
    logic              served_q, served_d;
    logic [31:0]       hits_q, hits_d;
    logic [31:0]       misses_q, misses_d;

    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic [OFF_W-1:0]  lookup_off;
    logic [IDX_W-1:0]  vsel_idx;
    logic [WAY_W-1:0]  vsel_way;
    logic              vsel_rr_used;
    logic              rr_advance;
    logic [31:0]       hit_data;
    logic              crit_now;
    logic              unused_addr_bits;

    assign lookup_idx = `ICACHE_ASSOC_IDX(cpu_addr, OFF_W, IDX_W);
    assign lookup_tag = `ICACHE_ASSOC_TAG(cpu_addr, OFF_W, IDX_W, ADDR_W);
    assign lookup_off = `ICACHE_ASSOC_OFF(cpu_addr, OFF_W);
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign tag_lookup_index = lookup_idx;
    assign tag_lookup_tag   = lookup_tag;
    assign data_read_index  = lookup_idx;
    assign data_read_offset = lookup_off;

    // Pointer reads use the live lookup set; the advance targets the set being refilled.
    assign vsel_idx = (state_q == StRefill) ? miss_idx_q : lookup_idx;

    icache_victim_sel #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_victim_sel (
        .clk         (clk),
        .rst_n       (rst_n),
        .index       (vsel_idx),
        .valid_vec   (tag_valid_vec),
        .advance     (rr_advance),
        .flush_clear (flush),
        .way         (vsel_way),
        .rr_used     (vsel_rr_used)
    );

    always_comb begin
        hit_data = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (tag_hit_vec[i]) begin
                hit_data = data_read_data[32*i +: 32];
            end
        end
    end

    assign crit_now = refill_data_valid && (refill_word == miss_off_q) && !served_q;

    always_comb begin
        state_d        = state_q;
        cpu_ready_d    = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        refill_start_d = 1'b0;
        tag_update_d   = 1'b0;
        flush_all_d    = 1'b0;
        dwe_d          = 1'b0;
        dw_off_d       = dw_off_q;
        dw_data_d      = dw_data_q;
        refill_addr_d  = refill_addr_q;
        miss_idx_d     = miss_idx_q;
        miss_tag_d     = miss_tag_q;
        miss_off_d     = miss_off_q;
        victim_d       = victim_q;
        rr_used_d      = rr_used_q;
        crit_d         = crit_q;
        served_d       = served_q;
        hits_d         = hits_q;
        misses_d       = misses_q;
        rr_advance     = 1'b0;

        if (flush) begin
            flush_all_d = 1'b1;
            served_d    = 1'b0;
            unique case (state_q)
                // An accepted burst must be waited out before the arrays are reused.
                StRefill, StDrain: state_d = refill_done ? StIdle : StDrain;
                StMissReq:         state_d = refill_busy ? StDrain : StIdle;
                default:           state_d = StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) state_d = StCompare;
                end
                StCompare: begin
                    if (!cpu_req) begin
                        state_d = StIdle;
                    end else if (|tag_hit_vec) begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = hit_data;
                        hits_d      = hits_q + 32'd1;
                        state_d     = StIdle;
                    end else begin
                        refill_addr_d  = {cpu_addr[ADDR_W-1:OFF_W+2], {(OFF_W + 2){1'b0}}};
                        miss_idx_d     = lookup_idx;
                        miss_tag_d     = lookup_tag;
                        miss_off_d     = lookup_off;
                        victim_d       = vsel_way;
                        rr_used_d      = vsel_rr_used;
                        misses_d       = misses_q + 32'd1;
                        refill_start_d = 1'b1;
                        state_d        = StMissReq;
                    end
                end
                StMissReq: begin
                    if (refill_busy) state_d = StRefill;
                    else             refill_start_d = 1'b1;
                end
                StRefill: begin
                    if (refill_data_valid) begin
                        dwe_d     = 1'b1;
                        dw_off_d  = refill_word;
                        dw_data_d = refill_data;
                    end
                    if (crit_now) begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = refill_data;
                        crit_d      = refill_data;
                        served_d    = 1'b1;
                    end
                    if (refill_done) begin
                        tag_update_d = 1'b1;
                        if (!served_q && !crit_now) begin
                            cpu_ready_d = 1'b1;
                            cpu_rdata_d = crit_q;
                        end
                        rr_advance = rr_used_q;
                        served_d   = 1'b0;
                        state_d    = StIdle;
                    end
                end
                StDrain: begin
                    if (refill_done) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cpu_ready_q    <= 1'b0;
            cpu_rdata_q    <= '0;
            refill_start_q <= 1'b0;
            tag_update_q   <= 1'b0;
            flush_all_q    <= 1'b0;
            dwe_q          <= 1'b0;
            dw_off_q       <= '0;
            dw_data_q      <= '0;
            refill_addr_q  <= '0;
            miss_idx_q     <= '0;
            miss_tag_q     <= '0;
            miss_off_q     <= '0;
            victim_q       <= '0;
            rr_used_q      <= 1'b0;
            crit_q         <= '0;
            served_q       <= 1'b0;
            hits_q         <= '0;
            misses_q       <= '0;
        end else begin
            state_q        <= state_d;
            cpu_ready_q    <= cpu_ready_d;
            cpu_rdata_q    <= cpu_rdata_d;
            refill_start_q <= refill_start_d;
            tag_update_q   <= tag_update_d;
            flush_all_q    <= flush_all_d;
            dwe_q          <= dwe_d;
            dw_off_q       <= dw_off_d;
            dw_data_q      <= dw_data_d;
            refill_addr_q  <= refill_addr_d;
            miss_idx_q     <= miss_idx_d;
            miss_tag_q     <= miss_tag_d;
            miss_off_q     <= miss_off_d;
            victim_q       <= victim_d;
            rr_used_q      <= rr_used_d;
            crit_q         <= crit_d;
            served_q       <= served_d;
            hits_q         <= hits_d;
            misses_q       <= misses_d;
        end
    end

    assign cpu_ready         = cpu_ready_q;
    assign cpu_rdata         = cpu_rdata_q;
    assign refill_start      = refill_start_q;
    assign refill_addr       = refill_addr_q;
    assign tag_update_valid  = tag_update_q;
    assign tag_update_way    = victim_q;
    assign tag_update_index  = miss_idx_q;
    assign tag_update_tag    = miss_tag_q;
    assign tag_flush_all     = flush_all_q;
    assign data_write_enable = dwe_q;
    assign data_write_way    = victim_q;
    assign data_write_index  = miss_idx_q;
    assign data_write_offset = dw_off_q;
    assign data_write_data   = dw_data_q;
    assign stat_hits         = hits_q;
    assign stat_misses       = misses_q;

endmodule

// File: tb/tb_icache_ctrl_assoc.sv
// Scoreboard bench for icache_ctrl_assoc (WAYS=2, SETS=64, LINE_WORDS=4): expected responses,
// array writes and tag updates are queued at stimulus time and popped when the DUT emits them.
module tb_icache_ctrl_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic        cpu_req;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic [5:0]  tag_lookup_index;
    logic [21:0] tag_lookup_tag;
    logic [1:0]  tag_hit_vec;
    logic [1:0]  tag_valid_vec;
    logic        tag_update_valid;
    logic [0:0]  tag_update_way;
    logic [5:0]  tag_update_index;
    logic [21:0] tag_update_tag;
    logic        tag_flush_all;
    logic [5:0]  data_read_index;
    logic [1:0]  data_read_offset;
    logic [63:0] data_read_data;
    logic        data_write_enable;
    logic [0:0]  data_write_way;
    logic [5:0]  data_write_index;
    logic [1:0]  data_write_offset;
    logic [31:0] data_write_data;
    logic [31:0] refill_addr;
    logic        refill_start;
    logic        refill_busy;
    logic        refill_done;
    logic [31:0] refill_data;
    logic [1:0]  refill_word;
    logic        refill_data_valid;
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_cnt = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [63:0] rsp_q [$];
    logic [63:0] wr_q  [$];
    logic [63:0] tag_q [$];

    icache_ctrl_assoc dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cpu_addr          (cpu_addr),
        .cpu_req           (cpu_req),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .flush             (flush),
        .tag_lookup_index  (tag_lookup_index),
        .tag_lookup_tag    (tag_lookup_tag),
        .tag_hit_vec       (tag_hit_vec),
        .tag_valid_vec     (tag_valid_vec),
        .tag_update_valid  (tag_update_valid),
        .tag_update_way    (tag_update_way),
        .tag_update_index  (tag_update_index),
        .tag_update_tag    (tag_update_tag),
        .tag_flush_all     (tag_flush_all),
        .data_read_index   (data_read_index),
        .data_read_offset  (data_read_offset),
        .data_read_data    (data_read_data),
        .data_write_enable (data_write_enable),
        .data_write_way    (data_write_way),
        .data_write_index  (data_write_index),
        .data_write_offset (data_write_offset),
        .data_write_data   (data_write_data),
        .refill_addr       (refill_addr),
        .refill_start      (refill_start),
        .refill_busy       (refill_busy),
        .refill_done       (refill_done),
        .refill_data       (refill_data),
        .refill_word       (refill_word),
        .refill_data_valid (refill_data_valid),
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_addr          = '0;
        cpu_req           = 1'b0;
        flush             = 1'b0;
        tag_hit_vec       = '0;
        tag_valid_vec     = '0;
        data_read_data    = '0;
        refill_busy       = 1'b0;
        refill_done       = 1'b0;
        refill_data       = '0;
        refill_word       = '0;
        refill_data_valid = 1'b0;
    endtask

    // Output monitor: every response, array write and tag update must match the next expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_ready) begin
                ready_cnt++;
                if (rsp_q.size() == 0) check("rsp_unexpected", 64'(1), 64'(0));
                else check("rsp_data", 64'(cpu_rdata), rsp_q.pop_front());
            end
            if (data_write_enable) begin
                if (wr_q.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
                else check("wr_beat", 64'({data_write_way, data_write_index, data_write_offset,
                                           data_write_data}), wr_q.pop_front());
            end
            if (tag_update_valid) begin
                if (tag_q.size() == 0) check("tag_unexpected", 64'(1), 64'(0));
                else check("tag_update", 64'({tag_update_way, tag_update_index, tag_update_tag}),
                           tag_q.pop_front());
            end
        end
    end

    task automatic run_hit(input logic [31:0] addr, input logic [1:0] hit,
                           input logic [63:0] rd, input logic [31:0] exp);
        cpu_req = 1'b1;
        cpu_addr = addr;
        tag_hit_vec = hit;
        data_read_data = rd;
        rsp_q.push_back(64'(exp));
        tick();
        check("hit_lat1", 64'(cpu_ready), 64'(0));
        tick();
        exp_hits++;
        check("hit_ready", 64'(cpu_ready), 64'(1));
        check("stat_hits", 64'(stat_hits), 64'(exp_hits));
        cpu_req = 1'b0;
        tag_hit_vec = '0;
        tick();
    endtask

    // Starts a miss and leaves the DUT in REFILL with the burst accepted.
    task automatic start_miss(input logic [31:0] addr, input logic [1:0] valid);
        cpu_req = 1'b1;
        cpu_addr = addr;
        tag_valid_vec = valid;
        tag_hit_vec = '0;
        tick();
        check("cmp_no_start", 64'(refill_start), 64'(0));
        tick();
        exp_misses++;
        check("miss_start", 64'(refill_start), 64'(1));
        check("refill_addr", 64'(refill_addr), 64'({addr[31:4], 4'h0}));
        check("stat_misses", 64'(stat_misses), 64'(exp_misses));
        refill_busy = 1'b1;
        tick();
        check("start_drop", 64'(refill_start), 64'(0));
    endtask

    task automatic run_miss(input logic [31:0] addr, input logic [1:0] valid,
                            input logic exp_way, input bit done_last);
        logic [31:0] d;
        int r0;
        r0 = ready_cnt;
        start_miss(addr, valid);
        for (int w = 0; w < 4; w++) begin
            d = $urandom;
            refill_data_valid = 1'b1;
            refill_word = 2'(w);
            refill_data = d;
            wr_q.push_back(64'({exp_way, addr[9:4], 2'(w), d}));
            if (2'(w) == addr[3:2]) rsp_q.push_back(64'(d));
            if (w == 3 && done_last) begin
                refill_done = 1'b1;
                tag_q.push_back(64'({exp_way, addr[9:4], addr[31:10]}));
            end
            tick();
            check("early_restart", 64'(cpu_ready), 64'(2'(w) == addr[3:2]));
            if (w == 3 && done_last) check("tag_upd_same", 64'(tag_update_valid), 64'(1));
            if (2'(w) == addr[3:2]) cpu_req = 1'b0;
        end
        refill_data_valid = 1'b0;
        if (!done_last) begin
            refill_done = 1'b1;
            tag_q.push_back(64'({exp_way, addr[9:4], addr[31:10]}));
            tick();
            check("done_no_rsp", 64'(cpu_ready), 64'(0));
            check("tag_upd", 64'(tag_update_valid), 64'(1));
        end
        refill_done = 1'b0;
        refill_busy = 1'b0;
        tick();
        check("one_rsp", 64'(ready_cnt - r0), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("rst_ready", 64'(cpu_ready), 64'(0));
        check("rst_start", 64'(refill_start), 64'(0));
        check("rst_hits", 64'(stat_hits), 64'(0));
        check("rst_raddr", 64'(refill_addr), 64'(0));
        rst_n = 1'b1;
        tick();

        cpu_addr = 32'hABCD_E7F8;
        #1;
        check("lk_index", 64'(tag_lookup_index), 64'(6'h3F));
        check("lk_tag", 64'(tag_lookup_tag), 64'(22'h2AF379));
        check("rd_offset", 64'(data_read_offset), 64'(2'd2));

        // Cold miss with early restart on word 1.
        run_miss(32'h0000_0104, 2'b00, 1'b0, 1'b0);

        run_hit(32'h0000_0104, 2'b01, 64'hBBBB_0002_AAAA_0001, 32'hAAAA_0001);
        run_hit(32'h0000_0104, 2'b10, 64'hBBBB_0002_AAAA_0001, 32'hBBBB_0002);
        run_hit(32'h0000_0108, 2'b11, 64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0);

        // Round robin on set 0x10, then invalid-way preference leaves the pointer alone.
        run_miss(32'h0000_0500, 2'b11, 1'b0, 1'b0);
        run_miss(32'h0000_0900, 2'b11, 1'b1, 1'b0);
        run_miss(32'h0000_0D00, 2'b11, 1'b0, 1'b0);
        run_miss(32'h0000_1100, 2'b10, 1'b0, 1'b0);
        run_miss(32'h0000_1500, 2'b11, 1'b1, 1'b0);
        run_miss(32'h0000_1900, 2'b01, 1'b1, 1'b0);

        // Critical word last, then last data coinciding with refill_done.
        run_miss(32'h0000_090C, 2'b11, 1'b0, 1'b0);
        run_miss(32'h0000_0D0C, 2'b01, 1'b1, 1'b1);

        // Flush mid-refill: drain without writes or response.
        start_miss(32'h2000_004C, 2'b00);
        for (int w = 0; w < 2; w++) begin
            d = $urandom;
            refill_data_valid = 1'b1;
            refill_word = 2'(w);
            refill_data = d;
            wr_q.push_back(64'({1'b0, 6'h04, 2'(w), d}));
            tick();
        end
        refill_data_valid = 1'b0;
        flush = 1'b1;
        tick();
        check("flush_pulse", 64'(tag_flush_all), 64'(1));
        flush = 1'b0;
        for (int w = 2; w < 4; w++) begin
            refill_data_valid = 1'b1;
            refill_word = 2'(w);
            refill_data = $urandom;
            tick();
            check("drain_no_wr", 64'(data_write_enable), 64'(0));
            check("drain_no_rsp", 64'(cpu_ready), 64'(0));
        end
        refill_data_valid = 1'b0;
        refill_done = 1'b1;
        tick();
        check("drain_no_tag", 64'(tag_update_valid), 64'(0));
        check("flush_once", 64'(tag_flush_all), 64'(0));
        refill_done = 1'b0;
        refill_busy = 1'b0;
        tick();
        tick();
        exp_misses++;
        check("post_flush_miss", 64'(refill_start), 64'(1));
        check("post_flush_stat", 64'(stat_misses), 64'(exp_misses));
        flush = 1'b1;
        tick();
        check("flush_missreq", 64'(refill_start), 64'(0));
        flush = 1'b0;
        cpu_req = 1'b0;
        tick();

        // Flush cleared the set 0x10 pointer (it was 1 before).
        run_miss(32'h0000_1D00, 2'b11, 1'b0, 1'b0);

        // Reset in the middle of a refill.
        start_miss(32'h0000_0304, 2'b00);
        refill_data_valid = 1'b1;
        refill_word = 2'd0;
        refill_data = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_wr", 64'(data_write_enable), 64'(0));
        check("arst_raddr", 64'(refill_addr), 64'(0));
        check("arst_misses", 64'(stat_misses), 64'(0));
        check("arst_rdata", 64'(cpu_rdata), 64'(0));
        rsp_q.delete();
        wr_q.delete();
        tag_q.delete();
        clear_inputs();
        exp_hits = 0;
        exp_misses = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_hits", 64'(stat_hits), 64'(0));
        run_hit(32'h0000_0104, 2'b10, 64'h5555_6666_7777_8888, 32'h5555_6666);

        check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        check("wr_q_empty", 64'(wr_q.size()), 64'(0));
        check("tag_q_empty", 64'(tag_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_ctrl_assoc.md
Name: icache_ctrl_assoc

Overview:
- Parametrised successor of the direct-mapped I-cache controller: N-way set-associative lookup with configurable line length and set count.
- Per-set round-robin victim selection with invalid-way preference.
- Critical-word early restart: the CPU is released when the requested word arrives, while the rest of the line fills in the background.
- Flush-safe refill drain: a flush during refill waits out the AXI burst before returning to idle.
- Sits between the CPU fetch port and the tag/data arrays plus the AXI refill engine.

Parameters:
- ADDR_W, 32: CPU byte-address width.
- WAYS, 2: associativity; power of 2, range 1..8.
- SETS, 64: number of sets; power of 2.
- LINE_WORDS, 4: 32-bit words per line; power of 2, minimum 2.
- Derived: WAY_W=max(1,clog2(WAYS)), IDX_W=clog2(SETS), OFF_W=clog2(LINE_WORDS), TAG_W=ADDR_W-IDX_W-OFF_W-2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_W  fetch byte address.
- cpu_req  in  1  fetch request; held until cpu_ready.
- cpu_rdata  out  32  instruction word.
- cpu_ready  out  1  one-cycle response pulse.
- flush  in  1  invalidate the whole cache.
- tag_lookup_index  out  IDX_W  equals cpu_addr index field.
- tag_lookup_tag  out  TAG_W  equals cpu_addr tag field.
- tag_hit_vec  in  WAYS  per-way hit.
- tag_valid_vec  in  WAYS  per-way valid bits of the looked-up set.
- tag_update_valid  out  1  write tag/valid.
- tag_update_way  out  WAY_W.
- tag_update_index  out  IDX_W.
- tag_update_tag  out  TAG_W.
- tag_flush_all  out  1  clear all valid bits.
- data_read_index  out  IDX_W.
- data_read_offset  out  OFF_W.
- data_read_data  in  32*WAYS  way w occupies bits [32w+31:32w].
- data_write_enable  out  1.
- data_write_way  out  WAY_W.
- data_write_index  out  IDX_W.
- data_write_offset  out  OFF_W.
- data_write_data  out  32.
- refill_addr  out  ADDR_W  line-aligned refill address.
- refill_start  out  1.
- refill_busy  in  1.
- refill_done  in  1.
- refill_data  in  32.
- refill_word  in  OFF_W.
- refill_data_valid  in  1.
- stat_hits  out  32.
- stat_misses  out  32.

Behaviour:
- Reset: every registered output, the round-robin pointers, the served flag and all latched refill fields go to 0; state goes to IDLE.
- Lookup and data-read outputs are combinational from cpu_addr.
- Default each cycle: cpu_ready, refill_start, tag_update_valid, tag_flush_all and data_write_enable are 0.
- States:
  - IDLE: go to COMPARE when cpu_req=1.
  - COMPARE: if cpu_req=0, go to IDLE. On a hit (any bit of tag_hit_vec), the next cycle drives cpu_rdata from the lowest-numbered hitting way and pulses cpu_ready; stat_hits increments; go to IDLE. On a miss, latch the aligned address, index, tag, offset and victim way; stat_misses increments; go to MISS_REQ. Hit latency is 2 cycles from request.
  - Victim selection: the lowest invalid way in tag_valid_vec; if every way is valid, the set's round-robin pointer.
  - MISS_REQ: hold refill_start=1 until refill_busy=1, then go to REFILL.
  - REFILL: each refill_data_valid writes the array next cycle at (victim, index, refill_word, refill_data). When refill_word equals the latched offset and served=0, the next cycle drives cpu_rdata=refill_data, pulses cpu_ready and sets served=1 (early restart).
  - On refill_done: pulse tag_update_* for the victim way. If served=0, respond with the captured word in the same cycle. If the victim came from the round-robin pointer, the pointer increments mod WAYS. Clear served and go to IDLE.
  - REFILL while cpu_req=1 for a new address: the request is not serviced until IDLE (blocking cache). The CPU must not re-raise cpu_req for the same fetch after an early restart.
- Flush (checked before all other state actions):
  - tag_flush_all pulses the next cycle and all round-robin pointers reset to 0.
  - From IDLE, COMPARE or MISS_REQ: go to IDLE, dropping any pending response; refill_start deasserts.
  - From REFILL: go to DRAIN. DRAIN suppresses data/tag writes and cpu_ready, then goes to IDLE on refill_done.
  - A flush in MISS_REQ in the same cycle as refill_busy=1 also goes to DRAIN.
- Simultaneous refill_data_valid and refill_done: the write happens and done processing happens, both in that cycle.
- Statistics counters wrap modulo 2^32 and are unaffected by flush.
- WAYS=1 degenerates to direct-mapped with WAY_W=1; way outputs are held at 0.

Decomposition:
- Shared package icache_assoc_pkg holds:
  - the state encodings (IDLE, COMPARE, MISS_REQ, REFILL, DRAIN);
  - the derived-width functions;
  - the address-field slice macros.
- One sub-module, icache_victim_sel: per-set round-robin pointer storage plus invalid-first selection. Interface: index, valid vector, advance strobe and flush clear in; way and rr_used out.

Test Plan:
- WAYS=2, SETS=64, LINE_WORDS=4:
  - Cold miss at 0x0000_0104 with no valid ways -> refill_addr=0x0000_0100, victim way 0, stat_misses=1.
  - Burst delivering words 0,1,2,3: cpu_ready pulses the cycle after word 1 with that word's data. Tag update for way 0, index 0x10, happens at refill_done.
- Re-request 0x0000_0104 with tag_hit_vec=2'b01 -> cpu_ready 2 cycles after cpu_req, cpu_rdata equals data_read_data[31:0], stat_hits=1.
- Set 0x10 with both ways valid, three consecutive misses -> victims 0,1,0, so the round-robin pointer wraps. With one way invalid, that way is chosen and the pointer is unchanged.
- Refill returning the requested word last (offset 3, order 0,1,2,3) -> exactly one cpu_ready, after word 3. Data arriving in the same cycle as refill_done -> write and done are both processed in that cycle.
- flush after the second data beat -> tag_flush_all pulses, then DRAIN: no data_write_enable, no cpu_ready, no tag update until refill_done, then IDLE. A following request misses.
- rst_n low during REFILL -> all outputs 0 immediately; after release, state is IDLE and the counters read 0.
